// File: rtl/rx_comp_bank_ctrl.sv
// Ping-pong coefficient bank sequencer: snoops the compensation stream, swaps banks only
// at frame boundaries and steers host writes into the shadow bank. Optional: RXC_LEN_CHECK_EN.
module rx_comp_bank_ctrl #(
  parameter int DW       = 16,
  parameter int DATA_CNT = 1024,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tvalid_s,
  input  logic          tready_s,
  input  logic          tlast_s,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_wdata,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic          cfg_err,
  output logic [AW:0]   ram_raddr,
  output logic          ram_we,
  output logic [AW:0]   ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          bank_sel,
  output logic          swap_p,
`ifdef RXC_LEN_CHECK_EN
  output logic          len_err,
`endif
  output logic [15:0]   frame_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t        state;
  logic [AW-1:0] idx, idx_d;
  logic          hs, eof, swap, bank_d, last_idx;

  assign hs       = tvalid_s & tready_s;
  assign eof      = hs & tlast_s;
  assign last_idx = (idx == AW'(DATA_CNT - 1));

  // A commit in IDLE swaps immediately; otherwise the swap waits for the closing tlast.
  always_comb begin
    swap   = 1'b0;
    idx_d  = idx;
    case (state)
      IDLE:    swap = cfg_commit;
      RUN:     swap = cfg_commit & eof;
      PEND:    swap = eof;
      default: swap = 1'b0;
    endcase
    if (hs) idx_d = (tlast_s | last_idx) ? '0 : idx + AW'(1);
    bank_d = bank_sel ^ swap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      bank_sel  <= 1'b0;
      ram_raddr <= '0;
      swap_p    <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_err   <= 1'b0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      frame_cnt <= '0;
`ifdef RXC_LEN_CHECK_EN
      len_err   <= 1'b0;
`endif
    end else begin
      idx       <= idx_d;
      bank_sel  <= bank_d;
      ram_raddr <= {bank_d, idx_d};
      swap_p    <= swap;
      // Write bank is taken before this edge's swap, so it lands in the newly active bank.
      ram_we    <= cfg_we & (state != PEND);
      cfg_err   <= cfg_we & (state == PEND);
      if (cfg_we && state != PEND) begin
        ram_waddr <= {~bank_sel, cfg_addr};
        ram_wdata <= cfg_wdata;
      end
      if (eof) frame_cnt <= frame_cnt + 16'd1;
`ifdef RXC_LEN_CHECK_EN
      if ((eof && !last_idx) || (hs && !tlast_s && last_idx)) len_err <= 1'b1;
`endif
      case (state)
        IDLE: if (hs && !tlast_s) state <= RUN;
        RUN: begin
          if (eof) state <= IDLE;
          else if (cfg_commit) begin
            state    <= PEND;
            cfg_busy <= 1'b1;
          end
        end
        PEND: if (eof) begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_comp_bank_ctrl.sv
// Randomized + directed bench for rx_comp_bank_ctrl against a frame/bank-level reference model.
module tb_rx_comp_bank_ctrl;
  localparam int DW = 16, DATA_CNT = 1024, AW = 10;

  logic          clk = 1'b0, reset = 1'b1;
  logic          tvalid_s = 0, tready_s = 0, tlast_s = 0, cfg_we = 0, cfg_commit = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_busy, cfg_err, ram_we, bank_sel, swap_p;
  logic [AW:0]   ram_raddr, ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [15:0]   frame_cnt;
`ifdef RXC_LEN_CHECK_EN
  logic          len_err;
`endif

  rx_comp_bank_ctrl #(.DW(DW), .DATA_CNT(DATA_CNT), .AW(AW)) dut (
    .clk(clk), .reset(reset), .tvalid_s(tvalid_s), .tready_s(tready_s), .tlast_s(tlast_s),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .ram_raddr(ram_raddr), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .bank_sel(bank_sel), .swap_p(swap_p),
`ifdef RXC_LEN_CHECK_EN
    .len_err(len_err),
`endif
    .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is either open or not, with maybe a swap owed at its end.
  bit m_open, m_pend, m_bank, m_len, e_we, e_err, e_swap;
  int m_idx, m_fcnt, e_waddr, e_wdata;
  bit hs, endf, sw, o_pend, o_bank;
  int o_idx;

  always @(posedge clk) begin
    if (reset) begin
      m_open = 0; m_pend = 0; m_bank = 0; m_len = 0; m_idx = 0; m_fcnt = 0;
      e_we = 0; e_err = 0; e_swap = 0; e_waddr = 0; e_wdata = 0;
    end else begin
      hs = tvalid_s && tready_s; endf = hs && tlast_s;
      o_pend = m_pend; o_bank = m_bank; o_idx = m_idx; sw = 0;
      if (!m_open) begin
        sw = cfg_commit;
        m_open = hs && !tlast_s;
      end else if (!m_pend) begin
        if (endf) begin m_open = 0; sw = cfg_commit; end
        else if (cfg_commit) m_pend = 1;
      end else if (endf) begin
        m_open = 0; m_pend = 0; sw = 1;
      end
      if (hs) m_idx = tlast_s ? 0 : (m_idx + 1) % DATA_CNT;
      if (endf) m_fcnt = (m_fcnt + 1) % 65536;
      if ((endf && o_idx != DATA_CNT-1) || (hs && !tlast_s && o_idx == DATA_CNT-1)) m_len = 1;
      e_we = cfg_we && !o_pend;
      e_err = cfg_we && o_pend;
      if (e_we) begin
        e_waddr = (o_bank ? 0 : DATA_CNT) + int'(cfg_addr);
        e_wdata = int'(cfg_wdata);
      end
      e_swap = sw;
      if (sw) m_bank = !m_bank;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) if (chk_en) begin
    chk("raddr", 32'(ram_raddr), 32'((m_bank ? DATA_CNT : 0) + m_idx));
    chk("bank_sel", 32'(bank_sel), 32'(m_bank));
    chk("cfg_busy", 32'(cfg_busy), 32'(m_pend));
    chk("swap_p", 32'(swap_p), 32'(e_swap));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (e_we) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(e_waddr));
      chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
    end
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`ifdef RXC_LEN_CHECK_EN
    chk("len_err", 32'(len_err), 32'(m_len));
`endif
  end

  int swp_cnt;
  task automatic cyc();
    @(negedge clk);
    swp_cnt += int'(swap_p);
  endtask

  task automatic drive(input bit v, input bit r, input bit l, input bit c, input bit we,
                       input int a, input int d);
    tvalid_s = v; tready_s = r; tlast_s = l; cfg_commit = c; cfg_we = we;
    cfg_addr = AW'(a); cfg_wdata = DW'(d);
    cyc();
  endtask

  task automatic do_reset();
    reset = 1; drive(0, 0, 0, 0, 0, 0, 0); reset = 0;
  endtask

  int bad, busy_cnt;
  initial begin
    reset = 1; cyc(); chk_en = 1; cyc();
    chk("rst_raddr", 32'(ram_raddr), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_outs", {26'd0, cfg_busy, cfg_err, ram_we, bank_sel, swap_p, 1'b0}, 0);
    reset = 0;

    // Full frame: raddr steps 0..1023 then back to 0.
    bad = 0;
    for (int k = 0; k < DATA_CNT; k++) begin
      if (ram_raddr !== 11'(k)) bad++;
      drive(1, 1, k == DATA_CNT-1, 0, 0, 0, 0);
    end
    chk("seq_raddr_steps", 32'(bad), 0);
    chk("seq_raddr_end", 32'(ram_raddr), 0);
    chk("seq_frame_cnt", 32'(frame_cnt), 1);
    chk("seq_bank", 32'(bank_sel), 0);

    // Mid-frame commit at beat 100.
    bad = 0; busy_cnt = 0;
    for (int k = 0; k < DATA_CNT; k++) begin
      if (ram_raddr !== 11'(k)) bad++;
      drive(1, 1, k == DATA_CNT-1, k == 100, 0, 0, 0);
      if (k < DATA_CNT-1) busy_cnt += int'(cfg_busy);
    end
    chk("mid_raddr_bank0", 32'(bad), 0);
    chk("mid_busy_cycles", 32'(busy_cnt), 923);
    chk("mid_busy_end", 32'(cfg_busy), 0);
    chk("mid_swap_p", 32'(swap_p), 1);
    chk("mid_bank", 32'(bank_sel), 1);
    chk("mid_raddr_end", 32'(ram_raddr), 32'h400);

    // Idle commit with same-cycle write.
    do_reset();
    drive(0, 0, 0, 1, 1, 5, 16'h1234);
    chk("ic_ram_we", 32'(ram_we), 1);
    chk("ic_waddr", 32'(ram_waddr), 32'h405);
    chk("ic_wdata", 32'(ram_wdata), 32'h1234);
    chk("ic_bank", 32'(bank_sel), 1);
    chk("ic_swap_p", 32'(swap_p), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ic_swap_once", 32'(swap_p), 0);

    // Write while PEND, then a second commit.
    do_reset(); swp_cnt = 0;
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0, 0);
    chk("pend_busy", 32'(cfg_busy), 1);
    drive(1, 1, 0, 0, 1, 7, 16'hBEEF);
    chk("pend_we", 32'(ram_we), 0);
    chk("pend_err", 32'(cfg_err), 1);
    drive(1, 1, 0, 1, 0, 0, 0);
    chk("pend_err_once", 32'(cfg_err), 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    chk("pend_bank", 32'(bank_sel), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pend_one_swap", 32'(swp_cnt), 1);

    // Single-beat frame with commit in IDLE; an idle commit afterwards swaps at once.
    do_reset();
    drive(1, 1, 1, 1, 0, 0, 0);
    chk("sb_frame_cnt", 32'(frame_cnt), 1);
    chk("sb_bank", 32'(bank_sel), 1);
    chk("sb_busy", 32'(cfg_busy), 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("sb_still_idle", {30'd0, swap_p, bank_sel}, 32'b10);

`ifdef RXC_LEN_CHECK_EN
    do_reset();
    for (int k = 0; k <= 500; k++) drive(1, 1, k == 500, 0, 0, 0, 0);
    chk("len_short", 32'(len_err), 1);
    drive(0, 0, 0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0, 0, 0);
    chk("len_sticky", 32'(len_err), 1);
    do_reset();
    chk("len_reset", 32'(len_err), 0);
    for (int k = 0; k < 1030; k++) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      if (k == DATA_CNT-2) chk("len_pre_wrap", 32'(len_err), 0);
      if (k == DATA_CNT-1) chk("len_wrap", 32'(len_err), 1);
    end
`endif

    // Randomized traffic, including occasional mid-frame resets.
    do_reset();
    for (int n = 0; n < 20000; n++) begin
      reset = ($urandom_range(0, 1499) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, DATA_CNT-1)), int'($urandom_range(0, 65535)));
    end
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
